// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan counter.
// Mode encodings and the hex segment table.
package seg_pkg;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_PASS = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry n (n = 0..15) holds the a..g pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to seven-segment pattern.
// Segments a..g map to bit0..bit6, active high.
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup, purely combinational
    always_comb begin
        seg = SEG_HEX[nibble];
    end

endmodule

// File: rtl/seg_scan_counter.sv
// Multi-digit hex counter with a time-multiplexed
// seven-segment display driver.
module seg_scan_counter
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE_W = 16,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   ext_value,
    input  logic [PRESCALE_W-1:0] tick_div,
    input  logic                  blank_lz,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  wrap
);

    localparam int CW = 4 * DIGITS;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PRESCALE_W-1:0] prescaler;
    logic                  tick;
    logic [CW-1:0]         counter;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic [CW-1:0]         src;
    logic [DIGITS-1:0]     blank;
    logic                  upper_zero;
    logic [3:0]            nib;
    logic                  blank_sel;
    logic [DIGITS-1:0]     en_d;
    logic [6:0]            seg_nib;

    // Only an exact match ticks; a lowered tick_div lets the
    // prescaler roll over through all-ones rather than lock up.
    assign tick = (prescaler == tick_div);

    // Count-tick divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRESCALE_W'(1);
        end
    end

    // Counter with load priority and wrap pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                counter <= ext_value;
            end else if (tick) begin
                case (mode)
                    MODE_UP: begin
                        counter <= counter + CW'(1);
                        wrap    <= &counter;
                    end
                    MODE_DOWN: begin
                        counter <= counter - CW'(1);
                        wrap    <= ~|counter;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Scan slot timer and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (scan_idx == IW'(DIGITS - 1)) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + IW'(1);
            end
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Display source: live ext_value in pass-through
    always_comb begin
        src = (mode == MODE_PASS) ? ext_value : counter;
    end

    // Leading-zero blanking; digit 0 is never blanked
    always_comb begin
        upper_zero = 1'b1;
        blank      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (src[4*i +: 4] == 4'h0);
            blank[i]   = blank_lz && upper_zero && (i != 0);
        end
    end

    // Select the active digit's nibble, blank flag and enable
    always_comb begin
        nib       = 4'h0;
        blank_sel = 1'b0;
        en_d      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                nib       = src[4*i +: 4];
                blank_sel = blank[i];
                en_d[i]   = 1'b1;
            end
        end
    end

    seg7_hex_decode u_dec (
        .nibble (nib),
        .seg    (seg_nib)
    );

    // Registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out  <= SEG_BLANK;
            digit_en <= '0;
        end else begin
            seg_out  <= blank_sel ? SEG_BLANK : seg_nib;
            digit_en <= en_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_counter.sv
// Directed self-checking bench for seg_scan_counter.
// DIGITS=4, SCAN_DIV=4 for short scan slots.
module tb_seg_scan_counter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic        load;
    logic [15:0] ext_value;
    logic [15:0] tick_div;
    logic        blank_lz;
    logic [6:0]  seg_out;
    logic [3:0]  digit_en;
    logic        wrap;

    int n_cmp;
    int n_bad;
    int wraps;
    logic [6:0] seen [4];

    seg_scan_counter #(
        .DIGITS     (4),
        .PRESCALE_W (16),
        .SCAN_DIV   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .load      (load),
        .ext_value (ext_value),
        .tick_div  (tick_div),
        .blank_lz  (blank_lz),
        .seg_out   (seg_out),
        .digit_en  (digit_en),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_digit(input logic [3:0] want,
                              input int budget);
        for (int k = 0; k < budget; k++) begin
            if (digit_en == want) break;
            step(1);
        end
    endtask

    task automatic collect(input int n);
        for (int d = 0; d < 4; d++) seen[d] = 7'h7F;
        for (int k = 0; k < n; k++) begin
            step(1);
            for (int d = 0; d < 4; d++)
                if (digit_en[d]) seen[d] = seg_out;
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        mode      = 2'b00;
        load      = 1'b0;
        ext_value = 16'h0000;
        tick_div  = 16'd0;
        blank_lz  = 1'b0;

        // Reset state
        step(2);
        chk("rst_seg", 32'(seg_out), 32'h00);
        chk("rst_en", 32'(digit_en), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_cnt", 32'(dut.counter), 32'h0);

        // Count up every cycle
        rst_n = 1'b1;
        step(1);
        chk("first_en", 32'(digit_en), 32'h1);
        step(4);
        chk("up5", 32'(dut.counter), 32'h0005);
        mode = 2'b10;
        step(1);
        wait_digit(4'b0001, 20);
        chk("d0_en", 32'(digit_en), 32'h1);
        chk("d0_seg5", 32'(seg_out), 32'h6D);

        // Wrap upward past all-ones
        mode      = 2'b00;
        load      = 1'b1;
        ext_value = 16'hFFFE;
        step(1);
        load = 1'b0;
        chk("ld_fffe", 32'(dut.counter), 32'hFFFE);
        wraps = 0;
        step(1);
        if (wrap) wraps++;
        chk("up_ffff", 32'(dut.counter), 32'hFFFF);
        step(1);
        if (wrap) wraps++;
        chk("up_0000", 32'(dut.counter), 32'h0000);
        chk("up_wrap", 32'(wrap), 32'h1);
        step(1);
        if (wrap) wraps++;
        chk("up_0001", 32'(dut.counter), 32'h0001);
        chk("up_wraps", 32'(wraps), 32'd1);

        // Count down with tick every 3 clks
        mode      = 2'b11;
        tick_div  = 16'd2;
        load      = 1'b1;
        ext_value = 16'h0001;
        step(1);
        load = 1'b0;
        step(1);
        chk("dn_hold2", 32'(dut.counter), 32'h0001);
        step(1);
        chk("dn_0000", 32'(dut.counter), 32'h0000);
        chk("dn_nowrap", 32'(wrap), 32'h0);
        step(2);
        chk("dn_still0", 32'(dut.counter), 32'h0000);
        step(1);
        chk("dn_ffff", 32'(dut.counter), 32'hFFFF);
        chk("dn_wrap", 32'(wrap), 32'h1);

        // Hold freezes the value
        mode  = 2'b10;
        wraps = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (wrap) wraps++;
        end
        chk("hold_cnt", 32'(dut.counter), 32'hFFFF);
        chk("hold_wrap", 32'(wraps), 32'd0);

        // Pass-through with leading-zero blanking
        mode      = 2'b01;
        ext_value = 16'h0A3C;
        blank_lz  = 1'b1;
        step(1);
        collect(16);
        chk("pass_d0", 32'(seen[0]), 32'h39);
        chk("pass_d1", 32'(seen[1]), 32'h4F);
        chk("pass_d2", 32'(seen[2]), 32'h77);
        chk("pass_d3bl", 32'(seen[3]), 32'h00);
        blank_lz = 1'b0;
        step(1);
        collect(16);
        chk("pass_d3", 32'(seen[3]), 32'h3F);
        chk("pass_cnt", 32'(dut.counter), 32'hFFFF);

        // Value zero with blanking shows a single 0
        ext_value = 16'h0000;
        blank_lz  = 1'b1;
        step(1);
        collect(16);
        chk("zero_d0", 32'(seen[0]), 32'h3F);
        chk("zero_d1", 32'(seen[1]), 32'h00);

        // Load coinciding with a tick: load wins, no wrap
        mode = 2'b10;
        for (int k = 0; k < 10; k++) begin
            if (dut.prescaler == 16'd2) break;
            step(1);
        end
        chk("ps_align", 32'(dut.prescaler), 32'd2);
        mode      = 2'b00;
        load      = 1'b1;
        ext_value = 16'hFFFF;
        step(1);
        load = 1'b0;
        chk("ldtk_cnt", 32'(dut.counter), 32'hFFFF);
        chk("ldtk_wrap", 32'(wrap), 32'h0);
        step(3);
        chk("ldtk_next", 32'(dut.counter), 32'h0000);
        chk("ldtk_wrap2", 32'(wrap), 32'h1);

        // Asynchronous reset mid-slot
        mode = 2'b10;
        wait_digit(4'b0100, 20);
        chk("mid_en", 32'(digit_en), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(digit_en), 32'h0);
        chk("arst_seg", 32'(seg_out), 32'h00);
        chk("arst_cnt", 32'(dut.counter), 32'h0);
        step(1);
        rst_n = 1'b1;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
